// File: rtl/mult_pkg.sv
// Shared types and sizing for the iterative multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MULT_W    = 32;
  localparam int MULT_ITER = 32;

endpackage

// File: rtl/mult32_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, sign applied at the end.
// Busy for 32 cycles after start, then a one-cycle done pulse with hi/lo valid and held.
module mult32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q, mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic [WIDTH-1:0]     abs_a_d, abs_b_d;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   acc_d, prod_d;

  // Magnitudes of the most negative value wrap back onto themselves, which is
  // exactly the unsigned magnitude we want.
  always_comb begin
    abs_a_d = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    abs_b_d = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d   = {sum_d, acc_q[WIDTH-1:1]};
    prod_d  = neg_q ? (~acc_d + (2*WIDTH)'(1)) : acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= abs_a_d;
            mplier_q <= abs_b_d;
            neg_q    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            {hi_q, lo_q} <= prod_d;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboarded bench for mult32_seq: expected products queued at start, popped on done.
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];

  mult32_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'h0, x};
    ye = s ? {{32{y[31]}}, y} : {32'h0, y};
    return xe * ye;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_excl", {63'h0, busy & done}, 64'h0);
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 64'h1, 64'h0);
        else check("sb_result", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Run one operation; optionally pulse start again at E5 and E33 with other operands.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s, input bit inj);
    logic [63:0] exp;
    int busy_cnt;
    int done_k;
    exp = model(x, y, s);
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b1; a = x; b = y; sign = s;
    busy_cnt = 0;
    done_k   = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_k = k;
      if (inj && (k == 5 || k == 33)) start = 1'b1;
    end
    check("latency", 64'(done_k), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd32);
    check("result", {hi, lo}, exp);
    repeat (3) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("hold_busy", {63'h0, busy}, 64'h0);
      check("hold_done", {63'h0, done}, 64'h0);
      check("hold_result", {hi, lo}, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op(32'd3, 32'd5, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    do_op(32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'd1, 1'b1, 1'b1);
    do_op(32'd12345, 32'hFFFF_0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

    // Abort an operation mid-run; the partial result must never surface.
    @(negedge clk);
    start = 1'b1; a = 32'h0001_2345; b = 32'h0000_6789; sign = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'h0, busy}, 64'h0);
    check("arst_done", {63'h0, done}, 64'h0);
    check("arst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_hold_hilo", {hi, lo}, 64'h0);

    do_op(32'd7, 32'd6, 1'b0, 1'b0);
    check("lo_42", {32'h0, lo}, 64'd42);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
